ir_decode: RTL and testbench

Instruction-register and branch-resolution stage directly upstream of the multicycle control FSM. It latches the fetched 16-bit instruction and presents the opcode, compare-code and status flags the FSM branches on. It also builds the immediate and LLI/SLLI values for the register-write mux. During the FSM's two-cycle branch sequence it resolves conditional branches and issues the PC write.

---
 rtl/ir_decode.sv | 146 ++++++++++++++
 tb/tb_ir_decode.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_decode.sv
// ---------------------------------------------------------------------------
// ir_decode
//
// Instruction register and branch-resolution stage that sits in front of the
// multicycle control FSM. It holds the fetched instruction, the compare code
// and the ALU status flags the FSM branches on. It builds the immediate and
// LLI/SLLI values for the register-write mux. During the FSM's two-cycle
// branch sequence it computes the target, resolves the condition and raises
// the PC write.
//
// Ports
//   CLK         clock, rising edge
//   reset       asynchronous, active-high reset
//   irw         load instr_in into IR
//   instr_in    memory read data (instruction)
//   compcodew   load compcode from IR[11:10]
//   srw         load status flags {alu_zero, alu_neg}
//   alu_zero    ALU result == 0
//   alu_neg     ALU result sign bit
//   isBranch    branch-phase strobe from the control FSM
//   pc          current PC (already incremented)
//   regval      register-file read of rd
//   opcode      IR[15:12]
//   rd          IR[11:8]
//   rs          IR[7:4]
//   compcode    registered compare code
//   sr          registered flags {zero, neg}
//   imm_ext     sign-extended IR[7:0]
//   lli_value   {regval[W-1:8], IR[7:0]}
//   slli_value  {regval[W-9:0], IR[7:0]}
//   br_target   registered branch target
//   br_pcw      PC write request for a taken branch
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ir_decode #(
   parameter int W    = 16,
   parameter int OFFW = 10
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         irw,
   input  logic [W-1:0] instr_in,
   input  logic         compcodew,
   input  logic         srw,
   input  logic         alu_zero,
   input  logic         alu_neg,
   input  logic         isBranch,
   input  logic [W-1:0] pc,
   input  logic [W-1:0] regval,
   output logic [3:0]   opcode,
   output logic [3:0]   rd,
   output logic [3:0]   rs,
   output logic [1:0]   compcode,
   output logic [1:0]   sr,
   output logic [W-1:0] imm_ext,
   output logic [W-1:0] lli_value,
   output logic [W-1:0] slli_value,
   output logic [W-1:0] br_target,
   output logic         br_pcw
);

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   state_t         state_reg, state_next;
   logic [W-1:0]   ir_reg;
   logic [1:0]     compcode_reg;
   logic [1:0]     sr_reg;
   logic [W-1:0]   br_target_reg;
   logic           taken_reg;
   logic           capture;
   logic           cond_now;
   logic [W-1:0]   target_next;

   // Field decode is straight off the IR so Decode sees it with no extra latency.
   assign opcode     = ir_reg[15:12];
   assign rd         = ir_reg[11:8];
   assign rs         = ir_reg[7:4];
   assign compcode   = compcode_reg;
   assign sr         = sr_reg;
   assign br_target  = br_target_reg;
   assign imm_ext    = {{(W-8){ir_reg[7]}}, ir_reg[7:0]};
   assign lli_value  = {regval[W-1:8], ir_reg[7:0]};
   assign slli_value = {regval[W-9:0], ir_reg[7:0]};

   // Target wraps silently modulo 2^W.
   assign target_next = pc + {{(W-OFFW){ir_reg[OFFW-1]}}, ir_reg[OFFW-1:0]};

   // Condition is evaluated on the registered sr, so a coincident srw only
   // affects the next branch.
   always_comb begin
      cond_now = 1'b0;
      case (compcode_reg)
         2'd0:    cond_now = 1'b1;        // always
         2'd1:    cond_now = sr_reg[1];   // eq
         2'd2:    cond_now = ~sr_reg[1];  // ne
         default: cond_now = sr_reg[0];   // lt
      endcase
   end

   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      br_pcw     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (isBranch) begin
               capture    = 1'b1;
               state_next = ARMED;
            end
         end
         ARMED: begin
            // A low isBranch here is the abort path: no PC write, back to IDLE.
            br_pcw     = isBranch & taken_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         ir_reg        <= '0;
         compcode_reg  <= '0;
         sr_reg        <= '0;
         br_target_reg <= '0;
         taken_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (irw)
            ir_reg <= instr_in;
         if (compcodew)
            compcode_reg <= ir_reg[11:10];
         if (srw)
            sr_reg <= {alu_zero, alu_neg};
         if (capture) begin
            br_target_reg <= target_next;
            taken_reg     <= cond_now;
         end
      end
   end

endmodule

// File: tb/tb_ir_decode.sv
`timescale 1ns/1ps
module tb_ir_decode;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        irw = 1'b0;
   logic [15:0] instr_in = '0;
   logic        compcodew = 1'b0;
   logic        srw = 1'b0;
   logic        alu_zero = 1'b0;
   logic        alu_neg = 1'b0;
   logic        isBranch = 1'b0;
   logic [15:0] pc = '0;
   logic [15:0] regval = '0;
   logic [3:0]  opcode, rd, rs;
   logic [1:0]  compcode, sr;
   logic [15:0] imm_ext, lli_value, slli_value, br_target;
   logic        br_pcw;

   int checks = 0;
   int errors = 0;

   ir_decode #(.W(16), .OFFW(10)) dut (
      .CLK(CLK), .reset(reset), .irw(irw), .instr_in(instr_in),
      .compcodew(compcodew), .srw(srw), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .isBranch(isBranch), .pc(pc), .regval(regval),
      .opcode(opcode), .rd(rd), .rs(rs), .compcode(compcode), .sr(sr),
      .imm_ext(imm_ext), .lli_value(lli_value), .slli_value(slli_value),
      .br_target(br_target), .br_pcw(br_pcw)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_ir = '0;
   logic [1:0]  m_cc = '0;
   logic [1:0]  m_sr = '0;     // {zero, neg}
   logic [15:0] m_tgt = '0;
   logic        m_taken = 1'b0;
   logic        m_pending = 1'b0;  // previous cycle opened a branch

   function automatic logic [15:0] target_of(input logic [15:0] p, input logic [15:0] ir);
      int off;
      int sum;
      off = int'(ir[9:0]);
      if (off >= 512) off = off - 1024;
      sum = (int'(p) + off + 65536) % 65536;
      return sum[15:0];
   endfunction

   function automatic logic taken_of(input logic [1:0] cc, input logic [1:0] flags);
      logic zero_f, neg_f;
      zero_f = flags[1];
      neg_f  = flags[0];
      case (cc)
         2'd0:    return 1'b1;
         2'd1:    return zero_f;
         2'd2:    return !zero_f;
         default: return neg_f;
      endcase
   endfunction

   always @(posedge CLK or posedge reset) begin
      if (reset) begin
         m_ir <= '0; m_cc <= '0; m_sr <= '0; m_tgt <= '0;
         m_taken <= 1'b0; m_pending <= 1'b0;
      end else begin
         if (irw) m_ir <= instr_in;
         if (compcodew) m_cc <= m_ir[11:10];
         if (srw) m_sr <= {alu_zero, alu_neg};
         if (m_pending) begin
            m_pending <= 1'b0;
         end else if (isBranch) begin
            m_pending <= 1'b1;
            m_tgt     <= target_of(pc, m_ir);
            m_taken   <= taken_of(m_cc, m_sr);
         end
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge CLK) begin
      chk("opcode", 32'(opcode), 32'(m_ir[15:12]));
      chk("rd", 32'(rd), 32'(m_ir[11:8]));
      chk("rs", 32'(rs), 32'(m_ir[7:4]));
      chk("compcode", 32'(compcode), 32'(m_cc));
      chk("sr", 32'(sr), 32'(m_sr));
      chk("imm_ext", 32'(imm_ext), 32'(unsigned'(16'(signed'(m_ir[7:0])))));
      chk("lli_value", 32'(lli_value), 32'(regval & 16'hFF00) | 32'(m_ir[7:0]));
      chk("slli_value", 32'(slli_value), (32'(regval[7:0]) << 8) | 32'(m_ir[7:0]));
      chk("br_target", 32'(br_target), 32'(m_tgt));
      chk("br_pcw", 32'(br_pcw), 32'(isBranch && m_pending && m_taken));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic load_ir(input logic [15:0] v);
      irw = 1'b1; instr_in = v; tick(); irw = 1'b0;
      compcodew = 1'b1; tick(); compcodew = 1'b0;
   endtask

   task automatic set_flags(input logic z, input logic n);
      srw = 1'b1; alu_zero = z; alu_neg = n; tick(); srw = 1'b0;
   endtask

   // Two-cycle branch; checks the ARMED-cycle outputs against literals.
   task automatic branch2(input string name, input logic [15:0] p,
                          input logic [15:0] exp_tgt, input logic exp_pcw);
      pc = p; isBranch = 1'b1; tick();
      #1;
      chk({name, "_tgt"}, 32'(br_target), 32'(exp_tgt));
      chk({name, "_pcw"}, 32'(br_pcw), 32'(exp_pcw));
      tick(); isBranch = 1'b0;
   endtask

   initial begin
      regval = 16'h1234;
      tick(); tick();
      reset = 1'b0;

      // Reset with IR preloaded
      irw = 1'b1; instr_in = 16'hA123; tick(); irw = 1'b0;
      #1 chk("preload_opcode", 32'(opcode), 32'hA);
      reset = 1'b1;
      #1;
      chk("rst_opcode", 32'(opcode), 32'h0);
      chk("rst_rd", 32'(rd), 32'h0);
      chk("rst_imm", 32'(imm_ext), 32'h0);
      chk("rst_lli", 32'(lli_value), 32'h1200);
      chk("rst_slli", 32'(slli_value), 32'h3400);
      chk("rst_pcw", 32'(br_pcw), 32'h0);
      tick(); reset = 1'b0;

      // IR field decode
      irw = 1'b1; instr_in = 16'h6A85; tick(); irw = 1'b0;
      #1;
      chk("dec_opcode", 32'(opcode), 32'h6);
      chk("dec_rd", 32'(rd), 32'hA);
      chk("dec_rs", 32'(rs), 32'h8);
      chk("dec_imm", 32'(imm_ext), 32'hFF85);
      chk("dec_lli", 32'(lli_value), 32'h1285);
      chk("dec_slli", 32'(slli_value), 32'h3485);

      // eq branch taken / not taken
      load_ir(16'h9403);
      set_flags(1'b1, 1'b0);
      branch2("eq_taken", 16'h0010, 16'h0013, 1'b1);
      set_flags(1'b0, 1'b0);
      branch2("eq_not", 16'h0010, 16'h0013, 1'b0);

      // Wrap-around targets
      load_ir(16'h03FC);
      branch2("wrap_neg", 16'h0002, 16'hFFFE, 1'b1);
      load_ir(16'h0001);
      branch2("wrap_pos", 16'hFFFF, 16'h0000, 1'b1);

      // Aborted branch, then a normal one with irw during ARMED
      pc = 16'h0100; isBranch = 1'b1; tick(); isBranch = 1'b0;
      #1 chk("abort_pcw", 32'(br_pcw), 32'h0);
      tick();
      pc = 16'h0200; isBranch = 1'b1; tick();
      #1 chk("after_abort_pcw", 32'(br_pcw), 32'h1);
      irw = 1'b1; instr_in = 16'h0155; tick(); irw = 1'b0; isBranch = 1'b0;
      #1 chk("irw_armed_tgt", 32'(br_target), 32'h0201);
      chk("irw_armed_ir", 32'(opcode), 32'h0);
      chk("irw_armed_rs", 32'(rs), 32'h5);

      // srw coincident with capture uses the old flags
      load_ir(16'h9403);
      set_flags(1'b0, 1'b0);
      srw = 1'b1; alu_zero = 1'b1; pc = 16'h0010; isBranch = 1'b1; tick(); srw = 1'b0;
      #1 chk("srw_coinc_pcw", 32'(br_pcw), 32'h0);
      tick(); isBranch = 1'b0;
      #1 chk("srw_coinc_sr", 32'(sr), 32'h2);

      // Reset while ARMED
      isBranch = 1'b1; tick();
      #1 chk("armed_pcw", 32'(br_pcw), 32'h1);
      reset = 1'b1;
      #1;
      chk("rst_armed_pcw", 32'(br_pcw), 32'h0);
      chk("rst_armed_tgt", 32'(br_target), 32'h0);
      tick(); reset = 1'b0; isBranch = 1'b0;
      tick();

      // Sweep every compare code against every flag combination
      for (int cc = 0; cc < 4; cc++) begin
         for (int f = 0; f < 4; f++) begin
            logic [15:0] ins;
            ins = 16'h9005 | 16'(cc << 10);
            load_ir(ins);
            set_flags(f[1], f[0]);
            pc = 16'(16'h0400 + f);
            isBranch = 1'b1; tick(); tick(); isBranch = 1'b0;
            tick();
         end
      end
      // Held isBranch: alternating capture / fire
      load_ir(16'h0010);
      pc = 16'h1000; isBranch = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      isBranch = 1'b0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
